// File: rtl/quant_stream_if.sv
// Element streams of the quantizer: int accumulator stream in, quantized stream out.
// The unit is the slave on both streams; the producer/consumer side is the master.
interface quant_stream_if #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 8
);
    logic signed [IN_W-1:0] in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic [OUT_W-1:0]       out_data;
    logic                   out_valid;
    logic                   out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/quant_stream_unit.sv
// Streaming affine requantizer: out = sat(round((in * mult) >> shift) + zero_point),
// three-stage stallable pipeline with per-job saturation count.
//  state  | meaning
//  S_IDLE | waiting for start, config may be latched
//  S_RUN  | streaming elements until size outputs handed off
//  S_DONE | one-cycle done pulse, then back to idle
module quant_stream_unit #(
    parameter int IN_W       = 32,
    parameter int OUT_W      = 8,
    parameter int MULT_W     = 16,
    parameter int SHIFT_W    = 6,
    parameter int CNT_W      = 32,
    parameter bit SIGNED_OUT = 1'b1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic signed [MULT_W-1:0] i_mult,
    input  logic [SHIFT_W-1:0]       i_shift,
    input  logic [OUT_W-1:0]         i_zero_point,
    input  logic [CNT_W-1:0]         i_size,
    quant_stream_if.slave            s_strm,
    output logic                     o_busy,
    output logic                     o_ready,
    output logic                     o_done,
    output logic [CNT_W-1:0]         o_sat_count
);
    localparam int PW = IN_W + MULT_W;
    localparam int VW = PW + 2;
    localparam logic [PW:0] RND_ONE = 1;
    localparam logic signed [VW-1:0] MAXV = SIGNED_OUT ?
        {{(VW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}} : {{(VW-OUT_W){1'b0}}, {OUT_W{1'b1}}};
    localparam logic signed [VW-1:0] MINV = SIGNED_OUT ?
        {{(VW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}} : {VW{1'b0}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic signed [MULT_W-1:0]  r_mult;
    logic [SHIFT_W-1:0]        r_shift;
    logic [OUT_W-1:0]          r_zp;
    logic [CNT_W-1:0]          r_size;
    logic [CNT_W-1:0]          r_in_cnt;
    logic [CNT_W-1:0]          r_out_cnt;
    logic [CNT_W-1:0]          r_sat_cnt;

    logic                      r_v1, r_v2, r_v3;
    logic signed [PW-1:0]      r_prod;
    logic signed [PW:0]        r_r;
    logic [OUT_W-1:0]          r_out;
    logic                      r_sat;

    logic                      w_en;
    logic                      w_in_ready;
    logic                      w_accept;
    logic                      w_out_hs;
    logic                      w_start;
    logic signed [PW-1:0]      w_prod;
    logic [PW:0]               w_rnd;
    logic signed [PW:0]        w_sum;
    logic signed [PW:0]        w_r;
    logic signed [VW-1:0]      w_v;
    logic [OUT_W-1:0]          w_out;
    logic                      w_sat;

    assign w_en     = !r_v3 || s_strm.out_ready;
    assign w_accept = s_strm.in_valid && w_in_ready;
    assign w_out_hs = r_v3 && s_strm.out_ready;
    assign w_start  = (r_state == S_IDLE) && i_start;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        o_busy      = 1'b0;
        o_ready     = 1'b0;
        o_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_ready = 1'b1;
                if (i_start) w_state_nxt = (i_size == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                o_busy     = 1'b1;
                w_in_ready = (r_in_cnt < r_size) && w_en;
                if (w_out_hs && (r_out_cnt + CNT_W'(1) == r_size)) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                o_busy      = 1'b1;
                o_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mult    <= '0;
            r_shift   <= '0;
            r_zp      <= '0;
            r_size    <= '0;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            r_sat_cnt <= '0;
        end else if (w_start) begin
            r_mult    <= i_mult;
            r_shift   <= i_shift;
            r_zp      <= i_zero_point;
            r_size    <= i_size;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            r_sat_cnt <= '0;
        end else begin
            if (w_accept) r_in_cnt <= r_in_cnt + CNT_W'(1);
            if (w_out_hs) begin
                r_out_cnt <= r_out_cnt + CNT_W'(1);
                if (r_sat) r_sat_cnt <= r_sat_cnt + CNT_W'(1);
            end
        end
    end

    // Sums carry one extra bit so the rounding add and zero-point add never wrap before the clamp.
    always_comb begin
        w_prod = PW'(s_strm.in_data) * PW'(r_mult);
        w_rnd  = (r_shift == '0) ? '0 : (RND_ONE << (r_shift - SHIFT_W'(1)));
        w_sum  = {r_prod[PW-1], r_prod} + w_rnd;
        w_r    = w_sum >>> r_shift;
        w_v    = {r_r[PW], r_r} + {{(VW-OUT_W){r_zp[OUT_W-1]}}, r_zp};
        w_sat  = 1'b0;
        w_out  = w_v[OUT_W-1:0];
        if (w_v > MAXV) begin
            w_out = MAXV[OUT_W-1:0];
            w_sat = 1'b1;
        end else if (w_v < MINV) begin
            w_out = MINV[OUT_W-1:0];
            w_sat = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_v3   <= 1'b0;
            r_prod <= '0;
            r_r    <= '0;
            r_out  <= '0;
            r_sat  <= 1'b0;
        end else if (w_en) begin
            r_v1   <= w_accept;
            r_prod <= w_prod;
            r_v2   <= r_v1;
            r_r    <= w_r;
            r_v3   <= r_v2;
            r_out  <= w_out;
            r_sat  <= w_sat;
        end
    end

    assign s_strm.in_ready  = w_in_ready;
    assign s_strm.out_data  = r_out;
    assign s_strm.out_valid = r_v3;
    assign o_sat_count      = r_sat_cnt;
endmodule

// File: tb/tb_quant_stream_unit.sv
// Directed bench for quant_stream_unit: signed instance for the main jobs, unsigned
// instance for the unsigned clamp range.
module tb_quant_stream_unit;
    logic               clk = 1'b0;
    logic               rst;
    logic               start, start_u;
    logic signed [15:0] cfg_mult;
    logic [5:0]         cfg_shift;
    logic [7:0]         cfg_zp;
    logic [31:0]        cfg_size;
    logic               busy, rdy, done, busy_u, rdy_u, done_u;
    logic [31:0]        sat, sat_u;

    int n_vec = 0;
    int n_miss = 0;
    int cyc = 0;
    int stim[$];
    int expv[$];
    int q_out[$];
    int q_outu[$];
    int q_acc_cyc[$];
    int q_hs_cyc[$];
    int q_done_cyc[$];
    int g_ba, g_bh;

    quant_stream_if #(.IN_W(32), .OUT_W(8)) ifs ();
    quant_stream_if #(.IN_W(32), .OUT_W(8)) ifu ();

    quant_stream_unit #(.SIGNED_OUT(1'b1)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_mult(cfg_mult), .i_shift(cfg_shift),
        .i_zero_point(cfg_zp), .i_size(cfg_size), .s_strm(ifs),
        .o_busy(busy), .o_ready(rdy), .o_done(done), .o_sat_count(sat)
    );

    quant_stream_unit #(.SIGNED_OUT(1'b0)) u_dut_u (
        .i_clk(clk), .i_rst(rst), .i_start(start_u), .i_mult(cfg_mult), .i_shift(cfg_shift),
        .i_zero_point(cfg_zp), .i_size(cfg_size), .s_strm(ifu),
        .o_busy(busy_u), .o_ready(rdy_u), .o_done(done_u), .o_sat_count(sat_u)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ifs.in_valid && ifs.in_ready) q_acc_cyc.push_back(cyc);
        if (ifs.out_valid && ifs.out_ready) begin
            q_out.push_back(int'($signed(ifs.out_data)));
            q_hs_cyc.push_back(cyc);
        end
        if (done) q_done_cyc.push_back(cyc);
        if (ifu.out_valid && ifu.out_ready) q_outu.push_back(int'(ifu.out_data));
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string nm);
        chk({nm, "_in_ready"},  int'(ifs.in_ready), 0);
        chk({nm, "_out_valid"}, int'(ifs.out_valid), 0);
        chk({nm, "_out_data"},  int'(ifs.out_data), 0);
        chk({nm, "_busy"},      int'(busy), 0);
        chk({nm, "_ready"},     int'(rdy), 1);
        chk({nm, "_done"},      int'(done), 0);
        chk({nm, "_sat"},       int'(sat), 0);
    endtask

    task automatic start_job(input int m, input int sh, input int zp_i, input int sz);
        @(posedge clk); #1;
        cfg_mult  = 16'(m);
        cfg_shift = 6'(sh);
        cfg_zp    = 8'(zp_i);
        cfg_size  = 32'(sz);
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic feed(input bit sel, input int n);
        int idx = 0;
        int guard = 0;
        bit ok;
        while (idx < n && guard < 200) begin
            if (sel) begin ifu.in_valid = 1'b1; ifu.in_data = stim[idx]; end
            else     begin ifs.in_valid = 1'b1; ifs.in_data = stim[idx]; end
            @(negedge clk);
            ok = sel ? ifu.in_ready : ifs.in_ready;
            if (ok) idx++;
            @(posedge clk); #1;
            guard++;
        end
        ifs.in_valid = 1'b0;
        ifu.in_valid = 1'b0;
        if (guard >= 200) chk("feed_timeout", idx, n);
    endtask

    task automatic wait_done(input string nm, input int bd);
        int g = 0;
        while (q_done_cyc.size() == bd && g < 200) begin
            @(negedge clk); #1;
            g++;
        end
        if (q_done_cyc.size() == bd) chk({nm, "_done_timeout"}, 0, 1);
        else begin
            if (q_hs_cyc.size() > 0)
                chk({nm, "_done_lat"}, q_done_cyc[bd] - q_hs_cyc[q_hs_cyc.size()-1], 1);
            @(negedge clk); #1;
            chk({nm, "_ready_after"}, int'(rdy), 1);
        end
    endtask

    task automatic run_job(input string nm, input int m, input int sh, input int zp_i, input int exp_sat);
        int bo = q_out.size();
        int bd = q_done_cyc.size();
        g_ba = q_acc_cyc.size();
        g_bh = q_hs_cyc.size();
        start_job(m, sh, zp_i, stim.size());
        feed(1'b0, stim.size());
        wait_done(nm, bd);
        chk({nm, "_count"}, q_out.size() - bo, expv.size());
        for (int i = 0; i < expv.size(); i++)
            if (bo + i < q_out.size()) chk($sformatf("%s_out%0d", nm, i), q_out[bo+i], expv[i]);
        chk({nm, "_sat"}, int'(sat), exp_sat);
        repeat (3) @(negedge clk);
        #1;
        chk({nm, "_done_once"}, q_done_cyc.size() - bd, 1);
    endtask

    initial begin
        int nb;
        rst = 1'b1; start = 1'b0; start_u = 1'b0;
        cfg_mult = '0; cfg_shift = '0; cfg_zp = '0; cfg_size = '0;
        ifs.in_valid = 1'b0; ifs.in_data = '0; ifs.out_ready = 1'b1;
        ifu.in_valid = 1'b0; ifu.in_data = '0; ifu.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check_reset("rst");
        @(posedge clk); #1;
        rst = 1'b0;

        // T1: pass-through and latency
        stim = '{5, -5, 0, 127}; expv = '{5, -5, 0, 127};
        run_job("t1", 1, 0, 0, 0);
        if (q_hs_cyc.size() > g_bh && q_acc_cyc.size() > g_ba)
            chk("t1_latency", q_hs_cyc[g_bh] - q_acc_cyc[g_ba], 3);
        else chk("t1_latency_missing", 0, 1);

        // T2: rounding half toward +inf
        stim = '{3, -3, 1, -1}; expv = '{2, -1, 1, 0};
        run_job("t2", 1, 1, 0, 0);

        // T3: signed saturation with zero point
        stim = '{1000, -1000, 100}; expv = '{127, -128, 110};
        run_job("t3", 1, 0, 10, 2);

        // T3u: unsigned clamp range on the second instance
        stim = '{-5, 300};
        @(posedge clk); #1;
        cfg_mult = 16'sd1; cfg_shift = '0; cfg_zp = '0; cfg_size = 32'd2; start_u = 1'b1;
        @(posedge clk); #1;
        start_u = 1'b0;
        feed(1'b1, 2);
        repeat (8) @(negedge clk);
        #1;
        chk("t3u_count", q_outu.size(), 2);
        if (q_outu.size() == 2) begin
            chk("t3u_out0", q_outu[0], 0);
            chk("t3u_out1", q_outu[1], 255);
        end
        chk("t3u_sat", int'(sat_u), 2);

        // T4: output stall mid-stream
        stim = '{1, 2, 3, 4, -1, -2, -7, 100}; expv = '{1, 2, 2, 3, -1, -1, -5, 75};
        fork
            run_job("t4", 3, 2, 0, 0);
            begin : stall
                int g;
                g = 0;
                while (!ifs.out_valid && g < 50) begin @(negedge clk); #1; g++; end
                chk("t4_valid_seen", int'(ifs.out_valid), 1);
                @(posedge clk); #1;
                ifs.out_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk); #1;
                    chk($sformatf("t4_stall%0d_in_ready", k), int'(ifs.in_ready), 0);
                    chk($sformatf("t4_stall%0d_out_valid", k), int'(ifs.out_valid), 1);
                end
                @(posedge clk); #1;
                ifs.out_ready = 1'b1;
            end
        join

        // T5: size zero job
        nb = q_out.size();
        start_job(1, 0, 0, 0);
        @(negedge clk); #1;
        chk("t5_done_pulse", int'(done), 1);
        @(negedge clk); #1;
        chk("t5_done_low", int'(done), 0);
        chk("t5_ready", int'(rdy), 1);
        chk("t5_no_out", q_out.size() - nb, 0);

        // T5b: start during RUN is ignored
        stim = '{7, 8, 9}; expv = '{7, 8, 9};
        fork
            run_job("t5b", 1, 0, 0, 0);
            begin
                repeat (3) @(posedge clk);
                #1;
                cfg_mult = 16'sd5; cfg_size = 32'd1; cfg_zp = 8'd1; start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
                @(negedge clk); #1;
                chk("t5b_busy", int'(busy), 1);
            end
        join

        // T6: reset mid-job, then a fresh job
        stim = '{1000, 2000, 5, 6, 7, 8};
        start_job(1, 0, 0, 6);
        feed(1'b0, 4);
        rst = 1'b1;
        @(negedge clk); #1;
        chk("t6_sat_pre", int'(sat), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        check_reset("t6");
        nb = q_out.size();
        repeat (10) @(negedge clk);
        #1;
        chk("t6_no_emit", q_out.size() - nb, 0);

        stim = '{100, -200, 7}; expv = '{97, -128, 4};
        run_job("t6f", 2, 1, -3, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
